// File: rtl/gpio_host_link.sv
// gpio_host_link: toggle-handshake command bridge between the tiny processor's GPIO port and a 6-bit host stream.
// Build option GPIO_LINK_SYNC_EN: two-flop synchronizer on gpio_out ahead of request detection.
//
// state  | meaning
// IDLE   | gpio_out[2:0] at a request edge is a command
// PAY_LO | next request carries tx word bits [2:0]
// PAY_HI | next request carries tx word bits [5:3] and completes the write
module gpio_host_link #(
    parameter int RX_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] gpio_out,
    output logic [3:0] gpio_in,
    input  logic [5:0] host_rx_data,
    input  logic       host_rx_valid,
    output logic       host_rx_ready,
    output logic [5:0] host_tx_data,
    output logic       host_tx_valid,
    input  logic       host_tx_ready
);

    localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CNT_W = $clog2(RX_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_DEPTH);

    localparam logic [2:0] CMD_STATUS  = 3'd0;
    localparam logic [2:0] CMD_RD_LO   = 3'd1;
    localparam logic [2:0] CMD_RD_HI   = 3'd2;
    localparam logic [2:0] CMD_WRITE   = 3'd3;
    localparam logic [2:0] CMD_CLR_ERR = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        PAY_LO,
        PAY_HI
    } state_t;

    state_t           state;
    logic             req_seen;
    logic [2:0]       tx_lo;
    logic             tx_drop;
    logic [3:0]       gpio_eff;

    logic [5:0]       rx_mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] rx_count;

    logic             req;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_nonempty;
    logic             tx_busy;
    logic [5:0]       rx_head;

`ifdef GPIO_LINK_SYNC_EN
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= gpio_out;
            sync_q2 <= sync_q1;
        end
    end

    assign gpio_eff = sync_q2;
`else
    assign gpio_eff = gpio_out;
`endif

    // ready comes from the registered count only, so a pop at full does not admit a push that edge
    assign host_rx_ready = (rx_count != FULL_CNT);
    assign rx_nonempty   = (rx_count != '0);
    assign rx_push       = host_rx_valid && host_rx_ready;
    assign req           = (gpio_eff[3] != req_seen);
    assign rx_pop        = req && (state == IDLE) && (gpio_eff[2:0] == CMD_RD_HI) && rx_nonempty;
    assign rx_head       = rx_mem[rd_ptr];
    assign tx_busy       = host_tx_valid && !host_tx_ready;

    always_ff @(posedge clock) begin
        if (rx_push) begin
            rx_mem[wr_ptr] <= host_rx_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (rx_push && !rx_pop) begin
                rx_count <= rx_count + CNT_W'(1);
            end else if (rx_pop && !rx_push) begin
                rx_count <= rx_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            req_seen      <= 1'b0;
            gpio_in       <= '0;
            tx_lo         <= '0;
            tx_drop       <= 1'b0;
            host_tx_valid <= 1'b0;
            host_tx_data  <= '0;
        end else begin
            if (host_tx_valid && host_tx_ready) begin
                host_tx_valid <= 1'b0;
            end
            if (req) begin
                req_seen   <= gpio_eff[3];
                gpio_in[3] <= ~gpio_in[3];
                case (state)
                    IDLE: begin
                        case (gpio_eff[2:0])
                            CMD_STATUS: gpio_in[2:0] <= {rx_nonempty, tx_busy, tx_drop};
                            CMD_RD_LO:  gpio_in[2:0] <= rx_nonempty ? rx_head[2:0] : 3'b000;
                            CMD_RD_HI:  gpio_in[2:0] <= rx_nonempty ? rx_head[5:3] : 3'b000;
                            CMD_WRITE: begin
                                gpio_in[2:0] <= 3'b000;
                                state        <= PAY_LO;
                            end
                            CMD_CLR_ERR: begin
                                gpio_in[2:0] <= 3'b000;
                                tx_drop      <= 1'b0;
                            end
                            default: gpio_in[2:0] <= 3'b111;
                        endcase
                    end
                    PAY_LO: begin
                        tx_lo        <= gpio_eff[2:0];
                        gpio_in[2:0] <= 3'b000;
                        state        <= PAY_HI;
                    end
                    PAY_HI: begin
                        // a word being handed off this same edge frees the register, so no drop
                        if (tx_busy) begin
                            tx_drop      <= 1'b1;
                            gpio_in[2:0] <= 3'b000;
                        end else begin
                            host_tx_data  <= {gpio_eff[2:0], tx_lo};
                            host_tx_valid <= 1'b1;
                            gpio_in[2:0]  <= 3'b001;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
